// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - core-wide address and instruction widths
package core;
  localparam int ADDR_WIDTH = 30;
  localparam int INSN_WIDTH = 32;
endpackage

// File: rtl/insn_decode_pkg.sv
// rtl/insn_decode_pkg.sv - instruction decode helpers for move-from-sysreg
package InsnDecodePkg;
  localparam logic [5:0] OPC_MFS = 6'h2d;

  typedef struct packed {
    logic [4:0] group;
    logic [2:0] num;
    logic [1:0] pl;
  } sysreg_operand_t;

  function automatic logic insn_is_MFS(input logic [core::INSN_WIDTH-1:0] insn);
    return insn[31:26] == OPC_MFS;
  endfunction

  // Operand layout: group [25:21], number [20:18], privilege level [17:16]
  function automatic sysreg_operand_t insn_operand_sysreg(input logic [core::INSN_WIDTH-1:0] insn);
    return sysreg_operand_t'(insn[25:16]);
  endfunction
endpackage

// File: rtl/sreg_read_pkg.sv
// rtl/sreg_read_pkg.sv - state encoding and sysreg request record for the read stage
package sreg_read_pkg;
  localparam int SREG_GROUP_W = 5;
  localparam int SREG_NUM_W   = 3;
  localparam int SREG_PL_W    = 2;
  localparam int TIMER_W      = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DRAIN
  } sreg_state_e;

  typedef struct packed {
    logic [SREG_GROUP_W-1:0] group;
    logic [SREG_NUM_W-1:0]   num;
    logic [SREG_PL_W-1:0]    pl;
  } sreg_req_t;
endpackage

// File: rtl/sreg_rd_timer.sv
// rtl/sreg_rd_timer.sv - ack timeout counter; expired marks the tick that reaches TIMEOUT
module sreg_rd_timer
  import sreg_read_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic tick,
  output logic expired
);
  logic [TIMER_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_count <= '0;
    end else if (tick) begin
      r_count <= r_count + TIMER_W'(1);
    end
  end

  assign expired = tick && (r_count == TIMER_W'(TIMEOUT - 1));
endmodule

// File: rtl/sreg_read_stage.sv
// rtl/sreg_read_stage.sv - pipeline stage that resolves MFS sysreg reads before passing instructions on
module sreg_read_stage
  import sreg_read_pkg::*;
#(
  parameter int ADDR_WIDTH  = core::ADDR_WIDTH,
  parameter int INSN_WIDTH  = core::INSN_WIDTH,
  parameter int SREG_WIDTH  = 32,
  parameter int GROUP_WIDTH = 5,
  parameter int NUM_WIDTH   = 3,
  parameter int PL_WIDTH    = 2,
  parameter int TIMEOUT     = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ADDR_WIDTH-1:0]  in_addr,
  input  logic [INSN_WIDTH-1:0]  in_insn,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ADDR_WIDTH-1:0]  out_addr,
  output logic [INSN_WIDTH-1:0]  out_insn,
  output logic [SREG_WIDTH-1:0]  out_sreg_data,
  output logic                   out_sreg_fault,
  output logic                   sreg_rd_en,
  output logic [GROUP_WIDTH-1:0] sreg_rd_group,
  output logic [NUM_WIDTH-1:0]   sreg_rd_regnum,
  output logic [PL_WIDTH-1:0]    sreg_rd_plevel,
  input  logic                   sreg_rd_ack,
  input  logic [SREG_WIDTH-1:0]  sreg_rd_data,
  input  logic                   sreg_rd_fault
);
  localparam int DEC_W = core::INSN_WIDTH;

  sreg_state_e r_state, w_state_nxt;
  sreg_req_t   r_req;

  logic                  r_out_valid;
  logic [ADDR_WIDTH-1:0] r_out_addr;
  logic [INSN_WIDTH-1:0] r_out_insn;
  logic [SREG_WIDTH-1:0] r_out_data;
  logic                  r_out_fault;

  logic [DEC_W-1:0]                w_dec_insn;
  InsnDecodePkg::sysreg_operand_t  w_op;
  logic                  w_is_mfs;
  logic                  w_xfer;
  logic                  w_timer_clear;
  logic                  w_timer_tick;
  logic                  w_timer_expired;
  logic                  w_ld_plain;
  logic                  w_ld_mfs;
  logic                  w_ld_resp;
  logic [SREG_WIDTH-1:0] w_resp_data;
  logic                  w_resp_fault;

  assign w_dec_insn = DEC_W'(in_insn);
  assign w_is_mfs   = InsnDecodePkg::insn_is_MFS(w_dec_insn);
  assign w_op       = InsnDecodePkg::insn_operand_sysreg(w_dec_insn);

  assign in_ready = !rst && (r_state == S_IDLE) && (!r_out_valid || out_ready);
  assign w_xfer   = in_valid && in_ready;

  // The timer counts in DRAIN as well so a flushed request still gives up eventually
  assign w_timer_clear = (r_state == S_REQ);
  assign w_timer_tick  = ((r_state == S_WAIT) || (r_state == S_DRAIN)) && !sreg_rd_ack;

  sreg_rd_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (w_timer_clear),
    .tick    (w_timer_tick),
    .expired (w_timer_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_ld_plain   = 1'b0;
    w_ld_mfs     = 1'b0;
    w_ld_resp    = 1'b0;
    w_resp_data  = '0;
    w_resp_fault = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_xfer && !flush) begin
          if (w_is_mfs) begin
            w_ld_mfs    = 1'b1;
            w_state_nxt = S_REQ;
          end else begin
            w_ld_plain = 1'b1;
          end
        end
      end
      S_REQ, S_WAIT: begin
        if (sreg_rd_ack) begin
          w_state_nxt  = S_IDLE;
          w_ld_resp    = !flush;
          w_resp_data  = sreg_rd_data;
          w_resp_fault = sreg_rd_fault;
        end else if (w_timer_expired) begin
          w_state_nxt  = S_IDLE;
          w_ld_resp    = !flush;
          w_resp_fault = 1'b1;
        end else if (flush) begin
          w_state_nxt = S_DRAIN;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_DRAIN: begin
        if (sreg_rd_ack || w_timer_expired) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A new MFS can only be accepted once the held output is consumed, so out_* may be reused for it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_addr  <= '0;
      r_out_insn  <= '0;
      r_out_data  <= '0;
      r_out_fault <= 1'b0;
      r_req       <= '0;
    end else begin
      if (w_ld_plain) begin
        r_out_valid <= 1'b1;
        r_out_addr  <= in_addr;
        r_out_insn  <= in_insn;
        r_out_data  <= '0;
        r_out_fault <= 1'b0;
      end else if (w_ld_resp) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_resp_data;
        r_out_fault <= w_resp_fault;
      end else if (flush || out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_ld_mfs) begin
        r_out_addr  <= in_addr;
        r_out_insn  <= in_insn;
        r_req.group <= w_op.group;
        r_req.num   <= w_op.num;
        r_req.pl    <= w_op.pl;
      end
    end
  end

  assign out_valid      = r_out_valid;
  assign out_addr       = r_out_addr;
  assign out_insn       = r_out_insn;
  assign out_sreg_data  = r_out_data;
  assign out_sreg_fault = r_out_fault;
  assign sreg_rd_en     = !rst && (r_state == S_REQ);
  assign sreg_rd_group  = GROUP_WIDTH'(r_req.group);
  assign sreg_rd_regnum = NUM_WIDTH'(r_req.num);
  assign sreg_rd_plevel = PL_WIDTH'(r_req.pl);
endmodule

// File: doc/sreg_read_stage.md
SREG_READ_STAGE -- requirements
Module: sreg_read_stage

Interface
REQ-001 Parameters SHALL be:
- ADDR_WIDTH, default core::ADDR_WIDTH, word-address width.
- INSN_WIDTH, default core::INSN_WIDTH, instruction width.
- SREG_WIDTH, default 32, sysreg data width.
- GROUP_WIDTH, default 5, sysreg group field width.
- NUM_WIDTH, default 3, sysreg number field width.
- PL_WIDTH, default 2, privilege-level field width.
- TIMEOUT, default 15, maximum number of cycles to wait for an ack (legal range 1..255).

REQ-002 Ports SHALL be:
- clk, in, 1, single clock; all logic on its rising edge.
- rst, in, 1, synchronous, active-high reset.
- flush, in, 1, discards the held output and any in-flight MFS.
- in_valid, in, 1, upstream instruction valid.
- in_ready, out, 1, stage accepts the instruction this cycle.
- in_addr, in, ADDR_WIDTH, instruction word address.
- in_insn, in, INSN_WIDTH, instruction word.
- out_valid, out, 1, output register holds an instruction.
- out_ready, in, 1, downstream consumes the output.
- out_addr, out, ADDR_WIDTH, registered address.
- out_insn, out, INSN_WIDTH, registered instruction.
- out_sreg_data, out, SREG_WIDTH, MFS read result (0 for non-MFS).
- out_sreg_fault, out, 1, MFS read faulted or timed out.
- sreg_rd_en, out, 1, sysreg read request pulse.
- sreg_rd_group, out, GROUP_WIDTH, requested group.
- sreg_rd_regnum, out, NUM_WIDTH, requested number.
- sreg_rd_plevel, out, PL_WIDTH, requested privilege level.
- sreg_rd_ack, in, 1, sysreg read response valid.
- sreg_rd_data, in, SREG_WIDTH, response data.
- sreg_rd_fault, in, 1, response fault flag.

Function
REQ-003 FSM states SHALL be IDLE, REQ, WAIT and DRAIN.
REQ-004 in_ready SHALL equal (state==IDLE) and (out_valid==0 or out_ready==1); a transfer occurs when in_valid and in_ready are both 1.
REQ-005 A non-MFS transfer SHALL load out_addr and out_insn, zero out_sreg_data and out_sreg_fault, and set out_valid on the next edge (latency 1).
REQ-006 MFS detection and field extraction SHALL use InsnDecodePkg::insn_is_MFS and InsnDecodePkg::insn_operand_sysreg.
REQ-007 An MFS transfer SHALL latch addr, insn, group, num and pl, and move the FSM to REQ.
REQ-008 In REQ, sreg_rd_en SHALL be 1 for exactly that one cycle, with the latched fields driven; the FSM then moves to WAIT.
REQ-009 The sreg_rd_group, sreg_rd_regnum and sreg_rd_plevel outputs SHALL hold their values until the next request.
REQ-010 sreg_rd_ack SHALL be honoured in REQ and WAIT; on ack the output register loads sreg_rd_data and sreg_rd_fault, out_valid is set next edge, and the FSM returns to IDLE.
REQ-011 The timeout counter SHALL clear in REQ and increment each WAIT cycle without ack; when it reaches TIMEOUT, the output loads data=0 and fault=1, and the FSM goes to IDLE.
REQ-012 out_valid SHALL be 0 throughout REQ and WAIT.
REQ-013 While out_valid=1 and out_ready=0, all out_* signals SHALL hold stable.
REQ-014 flush SHALL clear out_valid next edge and has priority over a simultaneous transfer, which is dropped.
REQ-015 flush in REQ or WAIT SHALL move the FSM to DRAIN, still issuing the pending REQ pulse; DRAIN returns to IDLE on ack or timeout and discards the response; in_ready=0 throughout DRAIN.
REQ-016 An ack arriving in IDLE SHALL be ignored.

Reset
REQ-017 On rst all outputs SHALL be 0, the FSM SHALL be IDLE, and the timeout counter SHALL be 0; rst overrides flush and any in-flight request, with no drain.

Structure
REQ-018 The state enum and a sysreg request struct (group/num/pl) SHALL live in package sreg_read_pkg.
REQ-019 The timeout counter SHALL be sub-module sreg_rd_timer (ports: clk, rst, clear, tick, expired).

Verification
REQ-020 Non-MFS at addr=0x10, out_ready=1 -> out_valid the next cycle with out_insn equal to the input and data=0; back-to-back instructions give 1 per cycle.
REQ-021 MFS group=3, num=5, pl=1, ack 2 cycles after the pulse with data=0xDEADBEEF -> a single en pulse with fields 3/5/1, then out_sreg_data=0xDEADBEEF and fault=0.
REQ-022 MFS with no ack, TIMEOUT=15 -> out_valid exactly 16 cycles after the REQ cycle, fault=1, data=0.
REQ-023 out_ready held 0 for 5 cycles with out_valid=1 -> outputs stable and in_ready=0; the release cycle accepts the next instruction.
REQ-024 flush during WAIT, ack 3 cycles later with data=0x1234 -> no output produced, in_ready=0 until the ack, then IDLE.
REQ-025 rst asserted during WAIT -> next cycle all outputs 0 and IDLE; a subsequent ack is ignored.
